// File: rtl/d16_bus_pkg.sv
// d16 bus shared definitions: arbiter state encoding and default bus widths.
// Ports: none (package only).
// Imported by the arbiter interface, top and timeout counter.
package d16_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef logic [1:0] state_t;

  // GNT0/GNT1 are one-hot so the state value doubles as the {m1, m0} grant vector.
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_GNT0 = 2'd1;
  localparam state_t ST_GNT1 = 2'd2;

endpackage

// File: rtl/wb_arbiter2_if.sv
// Wishbone-classic bundle seen by the two-master arbiter: both master ports, the shared slave port, grant.
// Ports: i_m{0,1}_{cyc,stb,we,addr,dat} requests in, o_m{0,1}_{dat,ack,err} responses out,
//        o_s_{cyc,stb,we,addr,dat} to the slave, i_s_{dat,ack} from the slave, o_gnt one-hot grant.
interface wb_arbiter2_if
  import d16_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              i_m0_cyc, i_m0_stb, i_m0_we;
  logic [ADDR_W-1:0] i_m0_addr;
  logic [DATA_W-1:0] i_m0_dat;
  logic [DATA_W-1:0] o_m0_dat;
  logic              o_m0_ack, o_m0_err;

  logic              i_m1_cyc, i_m1_stb, i_m1_we;
  logic [ADDR_W-1:0] i_m1_addr;
  logic [DATA_W-1:0] i_m1_dat;
  logic [DATA_W-1:0] o_m1_dat;
  logic              o_m1_ack, o_m1_err;

  logic              o_s_cyc, o_s_stb, o_s_we;
  logic [ADDR_W-1:0] o_s_addr;
  logic [DATA_W-1:0] o_s_dat;
  logic [DATA_W-1:0] i_s_dat;
  logic              i_s_ack;

  logic [1:0]        o_gnt;

  // Arbiter side: sits as slave to both masters and drives the shared slave bus.
  modport slave (
    input  i_m0_cyc, i_m0_stb, i_m0_we, i_m0_addr, i_m0_dat,
    output o_m0_dat, o_m0_ack, o_m0_err,
    input  i_m1_cyc, i_m1_stb, i_m1_we, i_m1_addr, i_m1_dat,
    output o_m1_dat, o_m1_ack, o_m1_err,
    output o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_dat,
    input  i_s_dat, i_s_ack,
    output o_gnt
  );

  // Environment side: the masters' requests and the slave's responses.
  modport master (
    output i_m0_cyc, i_m0_stb, i_m0_we, i_m0_addr, i_m0_dat,
    input  o_m0_dat, o_m0_ack, o_m0_err,
    output i_m1_cyc, i_m1_stb, i_m1_we, i_m1_addr, i_m1_dat,
    input  o_m1_dat, o_m1_ack, o_m1_err,
    input  o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_dat,
    output i_s_dat, i_s_ack,
    input  o_gnt
  );

endinterface

// File: rtl/wb_timeout.sv
// Strobe watchdog: counts consecutive unacknowledged strobe cycles and pulses err on the TIMEOUT-th one.
// Ports: i_clk/i_reset_n, i_en (a master is granted), i_stb (granted master's strobe), i_ack (slave ack),
//        i_clr (granted master dropping cyc), o_err_pulse (combinational, same cycle as the threshold).
module wb_timeout
  import d16_bus_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  input  logic i_stb,
  input  logic i_ack,
  input  logic i_clr,
  output logic o_err_pulse
);

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_wait_cnt;
  logic       w_waiting;

  // The counter holds the number of earlier unacked strobe cycles, so the
  // threshold compare fires in the TIMEOUT-th such cycle; an ack in that cycle wins.
  assign w_waiting   = i_en & i_stb & ~i_ack;
  assign o_err_pulse = w_waiting & (r_wait_cnt == LP_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wait_cnt <= 8'd0;
    end else if (!w_waiting || o_err_pulse || i_clr) begin
      r_wait_cnt <= 8'd0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin arbiter for the d16 Wishbone-classic bus; grant is held for a whole cyc burst.
// Ports: i_clk, i_reset_n (async active-low), bus (wb_arbiter2_if.slave: both masters, slave bus, o_gnt).
// Latency: one cycle request-to-grant, one dead cycle between bursts; data/ack/stb paths are combinational.
module wb_arbiter2
  import d16_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  wb_arbiter2_if.slave   bus
);

  state_t            r_state, w_next;
  logic              r_last, w_last;   // master granted most recently
  logic [1:0]        w_gnt;
  logic              w_sel_cyc, w_sel_stb, w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_dat;
  logic              w_err;

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;               // m0 wins the first tie
    end else begin
      r_state <= w_next;
      r_last  <= w_last;
    end
  end

  // Next state: the grant is released only when the owner drops cyc.
  always_comb begin
    w_next = r_state;
    w_last = r_last;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_m0_cyc && bus.i_m1_cyc) w_next = r_last ? ST_GNT0 : ST_GNT1;
        else if (bus.i_m0_cyc)            w_next = ST_GNT0;
        else if (bus.i_m1_cyc)            w_next = ST_GNT1;
      end
      ST_GNT0: begin
        if (!bus.i_m0_cyc) begin
          w_next = ST_IDLE;
          w_last = 1'b0;
        end
      end
      ST_GNT1: begin
        if (!bus.i_m1_cyc) begin
          w_next = ST_IDLE;
          w_last = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_gnt = {r_state == ST_GNT1, r_state == ST_GNT0};

  // Request mux: everything reads zero when idle, so the slave sees no cyc/stb.
  always_comb begin
    w_sel_cyc  = 1'b0;
    w_sel_stb  = 1'b0;
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_dat  = '0;
    if (w_gnt[1]) begin
      w_sel_cyc  = bus.i_m1_cyc;
      w_sel_stb  = bus.i_m1_stb;
      w_sel_we   = bus.i_m1_we;
      w_sel_addr = bus.i_m1_addr;
      w_sel_dat  = bus.i_m1_dat;
    end else if (w_gnt[0]) begin
      w_sel_cyc  = bus.i_m0_cyc;
      w_sel_stb  = bus.i_m0_stb;
      w_sel_we   = bus.i_m0_we;
      w_sel_addr = bus.i_m0_addr;
      w_sel_dat  = bus.i_m0_dat;
    end
  end

  wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_en        (|w_gnt),
    .i_stb       (w_sel_stb),
    .i_ack       (bus.i_s_ack),
    .i_clr       (~w_sel_cyc),
    .o_err_pulse (w_err)
  );

  // Outputs: the strobe is withdrawn in the error cycle so the slave never
  // completes a transfer the master has already been told failed.
  always_comb begin
    bus.o_gnt    = w_gnt;
    bus.o_s_cyc  = w_sel_cyc;
    bus.o_s_stb  = w_sel_stb & ~w_err;
    bus.o_s_we   = w_sel_we;
    bus.o_s_addr = w_sel_addr;
    bus.o_s_dat  = w_sel_dat;
    bus.o_m0_ack = w_gnt[0] & bus.i_s_ack;
    bus.o_m0_err = w_gnt[0] & w_err;
    bus.o_m0_dat = w_gnt[0] ? bus.i_s_dat : '0;
    bus.o_m1_ack = w_gnt[1] & bus.i_s_ack;
    bus.o_m1_err = w_gnt[1] & w_err;
    bus.o_m1_dat = w_gnt[1] ? bus.i_s_dat : '0;
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios plus randomized traffic against a behavioural model.
// Ports: none (top-level bench).
module tb_wb_arbiter2;

  localparam int TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter2_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  wb_arbiter2 #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (TO)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {bus.o_gnt, bus.o_s_cyc, bus.o_s_stb, bus.o_s_we, bus.o_s_addr, bus.o_s_dat,
            bus.o_m0_dat, bus.o_m0_ack, bus.o_m0_err, bus.o_m1_dat, bus.o_m1_ack, bus.o_m1_err};
  endfunction

  // Behavioural model: who owns the bus, who owned it last, and how many
  // strobe cycles in a row have gone unanswered.
  int m_own  = -1, m_last = 1, m_age = 0;
  int n_own  = -1, n_last = 1, n_age = 0;

  always @(negedge clk) begin : model_cmp
    logic [1:0]  e_gnt;
    logic [34:0] e_s;
    logic [17:0] e_r0, e_r1;
    logic        c, s, we, err;
    logic [15:0] a, d;
    int          age_now;
    e_gnt = 2'b00; e_s = '0; e_r0 = '0; e_r1 = '0;
    if (!rst_n) begin
      n_own = -1; n_last = 1; n_age = 0;
    end else if (m_own < 0) begin
      n_own = m_own; n_last = m_last; n_age = 0;
      if (bus.i_m0_cyc && bus.i_m1_cyc) n_own = 1 - m_last;
      else if (bus.i_m0_cyc)            n_own = 0;
      else if (bus.i_m1_cyc)            n_own = 1;
    end else begin
      if (m_own == 0) begin
        c = bus.i_m0_cyc; s = bus.i_m0_stb; we = bus.i_m0_we; a = bus.i_m0_addr; d = bus.i_m0_dat;
      end else begin
        c = bus.i_m1_cyc; s = bus.i_m1_stb; we = bus.i_m1_we; a = bus.i_m1_addr; d = bus.i_m1_dat;
      end
      age_now = s ? m_age + 1 : 0;
      err     = s && !bus.i_s_ack && (age_now == TO);
      e_gnt   = (m_own == 0) ? 2'b01 : 2'b10;
      e_s     = {c, s && !err, we, a, d};
      if (m_own == 0) e_r0 = {bus.i_s_dat, bus.i_s_ack, err};
      else            e_r1 = {bus.i_s_dat, bus.i_s_ack, err};
      n_own = m_own; n_last = m_last;
      n_age = (s && !bus.i_s_ack && !err) ? age_now : 0;
      if (!c) begin
        n_own = -1; n_last = m_own; n_age = 0;
      end
    end
    chk("model_gnt",  bus.o_gnt, e_gnt);
    chk("model_sbus", {bus.o_s_cyc, bus.o_s_stb, bus.o_s_we, bus.o_s_addr, bus.o_s_dat}, e_s);
    chk("model_m0",   {bus.o_m0_dat, bus.o_m0_ack, bus.o_m0_err}, e_r0);
    chk("model_m1",   {bus.o_m1_dat, bus.o_m1_ack, bus.o_m1_err}, e_r1);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own = -1; m_last = 1; m_age = 0;
    end else begin
      m_own = n_own; m_last = n_last; m_age = n_age;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_m0_cyc = 0; bus.i_m0_stb = 0; bus.i_m0_we = 0; bus.i_m0_addr = '0; bus.i_m0_dat = '0;
    bus.i_m1_cyc = 0; bus.i_m1_stb = 0; bus.i_m1_we = 0; bus.i_m1_addr = '0; bus.i_m1_dat = '0;
    bus.i_s_ack  = 0; bus.i_s_dat  = '0;
  endtask

  logic       c0_t [10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
  logic       c1_t [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
  logic [1:0] g_t  [10] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};

  initial begin
    // Reset with both masters requesting
    clear_inputs();
    bus.i_m0_cyc = 1; bus.i_m0_stb = 1; bus.i_m1_cyc = 1; bus.i_m1_stb = 1;
    bus.i_s_ack = 1; bus.i_s_dat = 16'h1234;
    #3 chk("reset_outs", all_outs(), '0);
    tick(); tick();
    chk("reset_outs_held", all_outs(), '0);
    rst_n = 1;
    #2 chk("gnt_idle_at_release", bus.o_gnt, 2'b00);
    tick();
    #2 chk("gnt_first_tie_m0", bus.o_gnt, 2'b01);
    clear_inputs();
    tick(); tick();

    // Single read by m0
    bus.i_m0_cyc = 1; bus.i_m0_stb = 1; bus.i_m0_addr = 16'h1005;
    tick();
    #2 chk("read_gnt", bus.o_gnt, 2'b01);
    tick();
    bus.i_s_ack = 1; bus.i_s_dat = 16'hBEEF;
    #2;
    chk("read_m0_dat", bus.o_m0_dat, 16'hBEEF);
    chk("read_m0_ack", bus.o_m0_ack, 1'b1);
    chk("read_m1_ack", bus.o_m1_ack, 1'b0);
    chk("read_s_addr", bus.o_s_addr, 16'h1005);
    tick();
    clear_inputs();
    tick(); tick();

    // Fairness: fresh reset, both masters with 2-beat bursts re-requesting at once
    rst_n = 0;
    #1 rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      bus.i_m0_cyc = c0_t[k]; bus.i_m0_stb = c0_t[k];
      bus.i_m1_cyc = c1_t[k]; bus.i_m1_stb = c1_t[k];
      bus.i_s_ack  = 1;
      #2 chk($sformatf("fair_gnt_%0d", k), bus.o_gnt, g_t[k]);
      tick();
    end
    clear_inputs();
    tick(); tick();

    // Burst lock: m1 holds 5 beats while m0 keeps requesting (last owner was m0)
    bus.i_m0_cyc = 1; bus.i_m0_stb = 1; bus.i_m0_addr = 16'h0100;
    bus.i_m1_cyc = 1; bus.i_m1_stb = 1; bus.i_m1_addr = 16'h7000; bus.i_m1_we = 1; bus.i_m1_dat = 16'h00A5;
    tick();
    for (int b = 0; b < 5; b++) begin
      bus.i_s_ack = 1;
      #2;
      chk($sformatf("lock_gnt_%0d", b), bus.o_gnt, 2'b10);
      chk($sformatf("lock_addr_%0d", b), bus.o_s_addr, 16'h7000);
      tick();
    end
    bus.i_m1_cyc = 0; bus.i_m1_stb = 0; bus.i_s_ack = 0;
    #2 chk("lock_drop_cycle", bus.o_gnt, 2'b10);
    tick();
    #2 chk("lock_dead_cycle", bus.o_gnt, 2'b00);
    tick();
    #2 chk("lock_handover", bus.o_gnt, 2'b01);
    clear_inputs();
    tick(); tick();

    // Timeout: unmapped address, no ack
    bus.i_m0_cyc = 1; bus.i_m0_stb = 1; bus.i_m0_addr = 16'h2000;
    tick();
    for (int i = 1; i <= 4; i++) begin
      #2;
      chk($sformatf("to_err_c%0d", i), bus.o_m0_err, (i == 4));
      chk($sformatf("to_stb_c%0d", i), bus.o_s_stb, (i != 4));
      tick();
    end
    tick(); tick();
    bus.i_s_ack = 1;
    #2;
    chk("to_ack_wins_ack", bus.o_m0_ack, 1'b1);
    chk("to_ack_wins_err", bus.o_m0_err, 1'b0);
    tick();
    clear_inputs();
    tick(); tick();

    // Reset mid-burst in GNT1
    bus.i_m1_cyc = 1; bus.i_m1_stb = 1; bus.i_m1_addr = 16'h7000; bus.i_m1_we = 1; bus.i_m1_dat = 16'h5A5A;
    tick();
    #2;
    chk("mid_gnt", bus.o_gnt, 2'b10);
    chk("mid_stb", bus.o_s_stb, 1'b1);
    rst_n = 0;
    #1 chk("mid_reset_outs", all_outs(), '0);
    bus.i_m0_cyc = 1; bus.i_m0_stb = 1;
    tick();
    rst_n = 1;
    #2 chk("mid_release_idle", bus.o_gnt, 2'b00);
    tick();
    #2 chk("mid_release_m0_tie", bus.o_gnt, 2'b01);
    clear_inputs();
    tick(); tick();

    // Randomized traffic, with rare reset pulses
    for (int cyc_i = 0; cyc_i < 3000; cyc_i++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      bus.i_m0_cyc  = bus.i_m0_cyc ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      bus.i_m1_cyc  = bus.i_m1_cyc ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      bus.i_m0_stb  = bus.i_m0_cyc && ($urandom_range(0, 3) != 0);
      bus.i_m1_stb  = bus.i_m1_cyc && ($urandom_range(0, 3) != 0);
      bus.i_m0_we   = 1'($urandom_range(0, 1));
      bus.i_m1_we   = 1'($urandom_range(0, 1));
      bus.i_m0_addr = 16'($urandom);
      bus.i_m1_addr = 16'($urandom);
      bus.i_m0_dat  = 16'($urandom);
      bus.i_m1_dat  = 16'($urandom);
      bus.i_s_ack   = ($urandom_range(0, 4) == 0);
      bus.i_s_dat   = 16'($urandom);
      tick();
    end
    rst_n = 1;
    clear_inputs();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
